// File: rtl/fetch_decode_stage.sv
// Purpose: PC owner, instruction-memory requester and IF/ID pipeline register for the ASIP front end.
// Latency: a response accepted with stall low appears in IF/ID on the same edge, giving 1 instr/cycle.
// Backpressure: stall parks one response in a skid slot and pauses requests; redirect flushes IF/ID.
module fetch_decode_stage #(
    parameter int                  ADDR_W    = 32,
    parameter int                  INSTR_W   = 32,
    parameter logic [ADDR_W-1:0]   RESET_PC  = '0,
    parameter int                  PC_STEP   = 4,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc,
    output logic [ADDR_W-1:0]  id_pc_next,
    output logic [4:0]         id_opcode,
    output logic [2:0]         id_aluop
);

    // IDLE: one dead cycle after reset; REQ: request at pc; BUF: skid slot full, no request;
    // DRAIN: a redirected request is still outstanding and must complete before refetch.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BUF   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    state_t               state;
    state_t               state_nxt;
    logic [ADDR_W-1:0]    pc;
    logic [ADDR_W-1:0]    pc_nxt;
    logic [ADDR_W-1:0]    pend_tgt;
    logic [INSTR_W-1:0]   skid_instr;
    logic [ADDR_W-1:0]    skid_pc;

    // A response in REQ is usable only when no redirect squashes it.
    logic req_hit;
    logic load_from_mem;
    logic load_from_skid;
    logic park_in_skid;
    logic latch_target;

    assign req_hit        = (state == REQ) && imem_ready && !redirect;
    assign load_from_mem  = req_hit && !stall;
    assign park_in_skid   = req_hit && stall;
    assign load_from_skid = (state == BUF) && !stall && !redirect;
    // The outstanding request cannot be abandoned, so remember where to go once it completes.
    assign latch_target   = redirect && !imem_ready && ((state == REQ) || (state == DRAIN));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (imem_ready) begin
                    if (!redirect && stall) begin
                        state_nxt = BUF;
                    end else begin
                        state_nxt = REQ;
                    end
                end else if (redirect) begin
                    state_nxt = DRAIN;
                end
            end
            BUF: begin
                if (redirect || !stall) begin
                    state_nxt = REQ;
                end
            end
            DRAIN: begin
                if (imem_ready) begin
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request valid is a pure function of state; the address is always pc, which is frozen in DRAIN.
    always_comb begin
        imem_req  = (state == REQ) || (state == DRAIN);
        imem_addr = pc;
    end

    // Next PC: step on every accepted response, jump on redirect, resume at the latched target after a drain.
    always_comb begin
        pc_nxt = pc;
        case (state)
            IDLE: begin
                if (redirect) begin
                    pc_nxt = redirect_pc;
                end
            end
            REQ: begin
                if (imem_ready) begin
                    pc_nxt = redirect ? redirect_pc : pc + STEP;
                end
            end
            BUF: begin
                if (redirect) begin
                    pc_nxt = redirect_pc;
                end
            end
            DRAIN: begin
                if (imem_ready) begin
                    pc_nxt = redirect ? redirect_pc : pend_tgt;
                end
            end
            default: pc_nxt = pc;
        endcase
    end

    // PC register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_nxt;
        end
    end

    // Pending redirect target; the latest redirect before the drain completes wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_tgt <= '0;
        end else if (latch_target) begin
            pend_tgt <= redirect_pc;
        end
    end

    // Skid slot catches the response that arrives while the hazard unit stalls IF/ID.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_instr <= NOP_INSTR;
            skid_pc    <= '0;
        end else if (park_in_skid) begin
            skid_instr <= imem_rdata;
            skid_pc    <= pc;
        end
    end

    // IF/ID register: redirect flush beats stall; id_pc is left alone on a flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
            id_pc    <= '0;
        end else if (redirect) begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
        end else if (load_from_mem) begin
            id_valid <= 1'b1;
            id_instr <= imem_rdata;
            id_pc    <= pc;
        end else if (load_from_skid) begin
            id_valid <= 1'b1;
            id_instr <= skid_instr;
            id_pc    <= skid_pc;
        end
    end

    // Decode fields and the CALL link value.
    always_comb begin
        id_opcode  = id_instr[31:27];
        id_aluop   = id_instr[26:24];
        id_pc_next = id_pc + STEP;
    end

endmodule
